// File: rtl/arb_dyn_pri_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arb_dyn_pri_rr                                                 |
// | Purpose  : Dynamic-priority arbiter, round-robin tie-break, aging, hold.  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+

package arb_dyn_pri_rr_pkg;
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction
endpackage

module arb_dyn_pri_rr
    import arb_dyn_pri_rr_pkg::*;
#(
    parameter int REQ_NUM    = 4,
    parameter int PRI_WIDTH  = 3,
    parameter int AGE_WIDTH  = 4,
    parameter int HOLD_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [REQ_NUM-1:0]            req,
    input  logic [REQ_NUM*PRI_WIDTH-1:0]  priorityLevel,
    input  logic [AGE_WIDTH-1:0]          ageThreshold,
    input  logic [HOLD_WIDTH-1:0]         holdMax,
    output logic [REQ_NUM-1:0]            grant,
    output logic                          grantValid,
    output logic [clog2(REQ_NUM)-1:0]     grantId
);

    localparam int c_ID_WIDTH  = clog2(REQ_NUM);
    localparam int c_KEY_WIDTH = PRI_WIDTH + 1;

    logic [c_ID_WIDTH-1:0]  r_rr_ptr;
    logic [HOLD_WIDTH-1:0]  r_hold_cnt;
    logic [HOLD_WIDTH-1:0]  r_hold_max;
    logic [AGE_WIDTH-1:0]   r_age_cnt [REQ_NUM];

    logic                   w_hold_last;
    logic                   w_rel;
    logic                   w_arb;
    logic                   w_mask;
    logic [REQ_NUM-1:0]     w_cand;
    logic [REQ_NUM-1:0]     w_urg;
    logic [c_KEY_WIDTH-1:0] w_key [REQ_NUM];
    logic                   w_found;
    logic [c_ID_WIDTH-1:0]  w_win;
    logic [c_KEY_WIDTH-1:0] w_best_key;
    logic [REQ_NUM-1:0]     w_onehot;
    logic [REQ_NUM-1:0]     w_new_grant;
    logic [c_ID_WIDTH-1:0]  w_rr_next;

    // Hold limit is latched at grant time so mid-tenure edits wait for the next arbitration.
    assign w_hold_last = (r_hold_max != '0) && (r_hold_cnt == r_hold_max - 1'b1);
    assign w_rel       = ~req[grantId] | w_hold_last;
    assign w_arb       = ~grantValid | w_rel;
    assign w_mask      = grantValid & w_hold_last & (|(req & ~grant));
    assign w_cand      = w_mask ? (req & ~grant) : req;

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            w_urg[i] = (ageThreshold != '0) && (r_age_cnt[i] >= ageThreshold);
            w_key[i] = {~w_urg[i], priorityLevel[PRI_WIDTH*i +: PRI_WIDTH]};
        end
    end

    // Strict less-than while scanning from the pointer keeps the first tied candidate.
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_found    = 1'b0;
        w_win      = '0;
        w_best_key = '1;
        for (int k = 0; k < REQ_NUM; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % REQ_NUM;
            if (w_cand[v_idx] && (!w_found || (w_key[v_idx] < w_best_key))) begin
                w_found    = 1'b1;
                w_win      = c_ID_WIDTH'(v_idx);
                w_best_key = w_key[v_idx];
            end
        end
    end

    assign w_onehot    = {{(REQ_NUM-1){1'b0}}, 1'b1} << w_win;
    assign w_new_grant = (w_arb && w_found) ? w_onehot : '0;
    assign w_rr_next   = (int'(w_win) == REQ_NUM - 1) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant      <= '0;
            grantValid <= 1'b0;
            grantId    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_hold_max <= '0;
        end else if (w_arb) begin
            r_hold_cnt <= '0;
            if (w_found) begin
                grant      <= w_onehot;
                grantValid <= 1'b1;
                grantId    <= w_win;
                r_rr_ptr   <= w_rr_next;
                r_hold_max <= holdMax;
            end else begin
                grant      <= '0;
                grantValid <= 1'b0;
                grantId    <= '0;
            end
        end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (!rst_n || !req[i] || grant[i] || w_new_grant[i]) begin
                r_age_cnt[i] <= '0;
            end else if (r_age_cnt[i] != '1) begin
                r_age_cnt[i] <= r_age_cnt[i] + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_dyn_pri_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_arb_dyn_pri_rr                                              |
// | Purpose  : Self-checking bench with behavioural arbiter model.           |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_arb_dyn_pri_rr;
    localparam int N  = 4;
    localparam int PW = 3;
    localparam int AW = 4;
    localparam int HW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*PW-1:0] priorityLevel;
    logic [AW-1:0]   ageThreshold;
    logic [HW-1:0]   holdMax;
    logic [N-1:0]    grant;
    logic            grantValid;
    logic [1:0]      grantId;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: owner index (-1 = none), pointer, tenure count and its limit, ages.
    int m_owner, m_rr, m_hold, m_hold_lim;
    int m_age [N];

    always #5 clk = ~clk;

    arb_dyn_pri_rr #(
        .REQ_NUM(N), .PRI_WIDTH(PW), .AGE_WIDTH(AW), .HOLD_WIDTH(HW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .priorityLevel(priorityLevel),
        .ageThreshold(ageThreshold), .holdMax(holdMax),
        .grant(grant), .grantValid(grantValid), .grantId(grantId)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  na [N];
        bit  arb, by_hold;
        int  lvl, key, minkey, win, cand;
        if (!rst_n) begin
            m_owner = -1; m_rr = 0; m_hold = 0; m_hold_lim = 0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
            return;
        end
        by_hold = 1'b0;
        if (m_owner < 0) arb = 1'b1;
        else begin
            by_hold = (m_hold_lim != 0) && (m_hold == m_hold_lim - 1);
            arb = !req[m_owner] || by_hold;
        end
        for (int i = 0; i < N; i++)
            na[i] = (!req[i] || i == m_owner) ? 0 : ((m_age[i] + 1 > 15) ? 15 : m_age[i] + 1);
        if (arb) begin
            cand = int'(req);
            if (m_owner >= 0 && by_hold && ((cand & ~(1 << m_owner)) != 0))
                cand = cand & ~(1 << m_owner);
            minkey = 1000;
            for (int i = 0; i < N; i++) if (cand[i]) begin
                lvl = int'(priorityLevel[PW*i +: PW]);
                key = ((ageThreshold != 0 && m_age[i] >= int'(ageThreshold)) ? 0 : 8) + lvl;
                if (key < minkey) minkey = key;
            end
            win = -1;
            for (int k = 0; k < N && win < 0; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (cand[i]) begin
                    lvl = int'(priorityLevel[PW*i +: PW]);
                    key = ((ageThreshold != 0 && m_age[i] >= int'(ageThreshold)) ? 0 : 8) + lvl;
                    if (key == minkey) win = i;
                end
            end
            m_hold = 0;
            m_owner = win;
            if (win >= 0) begin
                m_rr = (win + 1) % N;
                m_hold_lim = int'(holdMax);
                na[win] = 0;
            end
        end else begin
            m_hold = (m_hold + 1) % 16;
        end
        for (int i = 0; i < N; i++) m_age[i] = na[i];
    endtask

    // Called at a negedge; returns at the next negedge with outputs of the edge in between.
    task automatic tick(input logic r, input logic [N-1:0] rq, input logic [N*PW-1:0] lv,
                        input logic [AW-1:0] th, input logic [HW-1:0] hm);
        rst_n = r; req = rq; priorityLevel = lv; ageThreshold = th; holdMax = hm;
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b0, '0, '0, '0, '0);
        tick(1'b0, '0, '0, '0, '0);
    endtask

    always @(posedge clk) begin
        logic [N-1:0] one, exp_g;
        #1;
        if (chk_en) begin
            one   = 1;
            exp_g = (m_owner >= 0) ? (one << m_owner) : '0;
            chk("model_grant", int'(grant), int'(exp_g));
            chk("model_valid", int'(grantValid), (m_owner >= 0) ? 1 : 0);
            chk("model_id", int'(grantId), (m_owner >= 0) ? m_owner : 0);
        end
    end

    initial begin
        int seq [9];
        int last0, maxgap, cnt0;
        rst_n = 1'b0; req = '0; priorityLevel = '0; ageThreshold = '0; holdMax = '0;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        chk("reset_grant", int'(grant), 0);
        chk("reset_valid", int'(grantValid), 0);
        chk("reset_id", int'(grantId), 0);

        // Levels {3,1,1,2} for req3..req0.
        tick(1'b1, 4'b0110, {3'd3, 3'd1, 3'd1, 3'd2}, 4'd0, 4'd0);
        chk("lvl_first", int'(grant), 4'b0010);
        tick(1'b1, 4'b0100, {3'd3, 3'd1, 3'd1, 3'd2}, 4'd0, 4'd0);
        chk("handover", int'(grant), 4'b0100);
        chk("handover_id", int'(grantId), 2);

        do_reset();
        seq = '{1, 1, 2, 2, 4, 4, 8, 8, 1};
        for (int c = 0; c < 9; c++) begin
            tick(1'b1, 4'b1111, '0, 4'd0, 4'd2);
            chk($sformatf("hold2_seq%0d", c), int'(grant), seq[c]);
        end

        do_reset();
        last0 = 0; maxgap = 0; cnt0 = 0;
        for (int c = 1; c <= 40; c++) begin
            tick(1'b1, 4'b1111, {3'd0, 3'd0, 3'd0, 3'd7}, 4'd3, 4'd1);
            if (grant[0]) begin
                if (c - last0 > maxgap) maxgap = c - last0;
                last0 = c; cnt0++;
            end
        end
        if (40 - last0 > maxgap) maxgap = 40 - last0;
        chk("aging_maxgap_ok", (maxgap <= 3 + N) ? 1 : 0, 1);
        cnt0 = 0;
        for (int c = 0; c < 30; c++) begin
            tick(1'b1, 4'b1111, {3'd0, 3'd0, 3'd0, 3'd7}, 4'd0, 4'd1);
            if (grant[0]) cnt0++;
        end
        chk("noaging_req0", cnt0, 0);

        do_reset();
        cnt0 = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, 4'b0100, '0, 4'd0, 4'd0);
            if (grant == 4'b0100) cnt0++;
        end
        chk("unlimited_hold", cnt0, 20);
        tick(1'b1, 4'b0000, '0, 4'd0, 4'd0);
        chk("drop_grant", int'(grant), 0);
        chk("drop_valid", int'(grantValid), 0);

        do_reset();
        cnt0 = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1'b1, 4'b0010, '0, 4'd0, 4'd3);
            if (grant == 4'b0010) cnt0++;
        end
        chk("owner_rewins", cnt0, 12);

        do_reset();
        tick(1'b1, 4'b1000, '0, 4'd0, 4'd0);
        chk("pre_rst_grant", int'(grant), 4'b1000);
        tick(1'b0, 4'b1111, '0, 4'd0, 4'd0);
        chk("midrst_grant", int'(grant), 0);
        tick(1'b1, 4'b1111, '0, 4'd0, 4'd0);
        chk("post_rst_rr", int'(grant), 4'b0001);

        for (int c = 0; c < 1500; c++) begin
            logic [N*PW-1:0] lv;
            for (int i = 0; i < N; i++) lv[PW*i +: PW] = PW'($urandom_range(0, 2));
            tick(($urandom_range(0, 59) != 0), N'($urandom), lv,
                 AW'($urandom_range(0, 5)), HW'($urandom_range(0, 3)));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/arb_dyn_pri_rr.md
Name: arb_dyn_pri_rr

Overview:
Parametrised dynamic-priority arbiter for REQ_NUM requesters with a per-requester runtime priority level. Ties at equal level are broken round-robin, not by fixed index. Aging promotes starved requesters, and a programmable hold limit bounds grant tenure. It sits between bus masters and a shared slave or port, and re-arbitrates back-to-back with no idle bubble.

Parameters:
REQ_NUM, 4, number of requesters (>=2)
PRI_WIDTH, 3, bits per priority level; level 0 = highest
AGE_WIDTH, 4, width of per-requester aging counter and ageThreshold
HOLD_WIDTH, 4, width of hold counter and holdMax

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
req  in  REQ_NUM  request vector, level-sensitive
priorityLevel  in  REQ_NUM*PRI_WIDTH  level of requester i at bits [PRI_WIDTH*(i+1)-1 : PRI_WIDTH*i]
ageThreshold  in  AGE_WIDTH  pending cycles before urgent promotion; 0 disables aging
holdMax  in  HOLD_WIDTH  max consecutive grant cycles; 0 = unlimited
grant  out  REQ_NUM  one-hot or zero grant, registered
grantValid  out  1  OR of grant, registered
grantId  out  clog2(REQ_NUM)  index of granted requester, registered; 0 when no grant

Behaviour:
- Reset (rst_n low at clk edge): grant=0, grantValid=0, grantId=0, rrPtr=0, all ageCnt=0, holdCnt=0. Reset mid-grant drops the grant the next edge.
- States: IDLE (grant==0), OWNED (one grant bit set, owner o).
- Release condition in OWNED: rel = ~req[o] | (holdMax!=0 & holdCnt==holdMax-1).
- Arbitrate when IDLE, or when OWNED and rel. The result is registered at the same edge, so latency from req to grant is 1 cycle and handover has no bubble.
- Candidate set: req masked with ~grant[o] only when release is by hold expiry and at least one other req is set. Otherwise the owner may re-win.
- Urgent: urg[i] = ageThreshold!=0 & ageCnt[i] >= ageThreshold.
- Effective key: {~urg[i], priorityLevel[i]}; the smallest key wins.
- Tie at the smallest key: the winner is the first candidate scanning cyclically from rrPtr upward (rrPtr, rrPtr+1, ..., wrap to 0).
- On every new grant to w: rrPtr <= (w+1) mod REQ_NUM, holdCnt <= 0, ageCnt[w] <= 0.
- In OWNED without rel: holdCnt increments each cycle. The grant is not preempted by higher-priority or urgent arrivals.
- No candidates at arbitration: go to IDLE (grant=0). rrPtr is unchanged.
- ageCnt[i]: cleared when req[i]=0 or when i is granted. Otherwise it increments each cycle req[i]&~grant[i] holds, saturating at all-ones.
- priorityLevel, ageThreshold and holdMax are sampled only on the arbitration cycle. Changes during tenure take effect at the next arbitration.
- Invariants: grant is always one-hot or zero. grantId matches the grant index. grant is never set for a requester whose req was low at the deciding edge.
- Width rules: clog2 is computed by a constant function. Counter compares are unsigned.

Test Plan:
- Reset, then req=4'b0110 with levels {3,1,1,2} (req3..req0) -> grant=4'b0010 one cycle later. Release req1 -> grant=4'b0100 at the same edge (rr tie-break, no bubble).
- Equal levels 0, req=4'b1111 held, holdMax=2 -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001.
- Levels {0,0,0,7}, req=4'b1111, holdMax=1, ageThreshold=3 -> req0 is granted at least once within every 3+REQ_NUM cycles. With ageThreshold=0 req0 is never granted.
- holdMax=0, single req2 held 20 cycles -> grant=4'b0100 for all 20 cycles. Drop req2 -> grant=0 and grantValid=0 next edge.
- holdMax=3, only req1 asserted continuously -> grant stays 4'b0010 across expiry (owner re-wins), holdCnt restarts.
- rst_n low for one edge while grant=4'b1000 -> grant=0, then rrPtr=0 tie-break favours req0 on equal levels.
